mem_tracker: RTL and testbench

- Load/store trace stage directly downstream of the IF tracker in the Gouram trace unit.
- Queues each load/store record emitted by the IF tracker.
- Pairs each queued record, in order, with the next transaction on the core's data-memory interface.
- Emits one completed trace record per instruction, with timestamps for IF end, memory request start and memory response end.

---
 rtl/gouram_pkg.sv | 51 +++++
 rtl/trace_fifo.sv | 54 +++++
 rtl/mem_tracker.sv | 147 ++++++++++++++
 tb/tb_mem_tracker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gouram_pkg.sv
// Shared types for the Gouram trace unit: IF/memory trace records, tracker FSM
// states and load/store opcode classification.
package gouram_pkg;

    localparam int INSTR_ADDR_W = 16;
    localparam int INSTR_DATA_W = 32;
    localparam int DATA_ADDR_W  = 32;

    localparam logic [7:0] LOAD_OP_LO  = 8'h03;
    localparam logic [7:0] LOAD_OP_HI  = 8'h83;
    localparam logic [7:0] STORE_OP_LO = 8'h23;
    localparam logic [7:0] STORE_OP_HI = 8'hA3;

    typedef struct packed {
        logic [INSTR_DATA_W-1:0] instruction;
        logic [INSTR_ADDR_W-1:0] instr_addr;
    } trace_format;

    typedef struct packed {
        logic [INSTR_DATA_W-1:0] instruction;
        logic [INSTR_ADDR_W-1:0] instr_addr;
        logic [31:0]             if_end;
    } if_entry_t;

    typedef struct packed {
        logic [INSTR_DATA_W-1:0] instruction;
        logic [INSTR_ADDR_W-1:0] instr_addr;
        logic [31:0]             if_end;
        logic [31:0]             mem_start;
        logic [31:0]             mem_end;
        logic [DATA_ADDR_W-1:0]  mem_addr;
        logic                    is_store;
        logic                    mismatch;
    } mem_trace_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        EMIT
    } state_t;

    function automatic logic is_store_op(input logic [INSTR_DATA_W-1:0] instr);
        return (instr[7:0] == STORE_OP_LO) || (instr[7:0] == STORE_OP_HI);
    endfunction

    function automatic logic is_load_op(input logic [INSTR_DATA_W-1:0] instr);
        return (instr[7:0] == LOAD_OP_LO) || (instr[7:0] == LOAD_OP_HI);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a combinational head. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; there is no bypass.
module trace_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_tracker.sv
// Pairs queued IF load/store records, in order, with data-memory transactions
// and emits one completed trace record per instruction.
module mem_tracker
    import gouram_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH = 16,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int DATA_ADDR_WIDTH  = 32,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                counter,
    input  logic                       if_data_ready,
    input  trace_format                if_data_i,
    input  logic [31:0]                if_stage_end,
    input  logic                       data_req,
    input  logic                       data_gnt,
    input  logic                       data_we,
    input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
    input  logic                       data_rvalid,
    output logic                       mem_data_ready,
    output mem_trace_t                 mem_data_o,
    output logic                       overflow,
    output logic                       orphan
);

    state_t    state;
    state_t    state_next;
    if_entry_t push_entry;
    if_entry_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      orphan_start;
    logic      skip_active;
    logic      skip_gnt;
    logic      latch_addr;
    logic      finish;

    logic [INSTR_DATA_WIDTH-1:0] wk_instr;
    logic [INSTR_ADDR_WIDTH-1:0] wk_iaddr;
    logic [31:0]                 wk_if_end;
    logic [31:0]                 wk_start;
    logic [DATA_ADDR_WIDTH-1:0]  wk_maddr;
    logic                        wk_we;
    mem_trace_t                  out_q;

    assign push_entry = '{instruction: if_data_i.instruction,
                          instr_addr:  if_data_i.instr_addr,
                          if_end:      if_stage_end};

    trace_fifo #(
        .T     (if_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (if_data_ready),
        .wdata (push_entry),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A new request is only considered in IDLE once any orphaned transaction is fully absorbed.
    assign pop          = (state == IDLE) && data_req && !skip_active && !fifo_empty;
    assign orphan_start = (state == IDLE) && data_req && !skip_active && fifo_empty;
    assign latch_addr   = (pop && data_gnt) || ((state == WAIT_GNT) && data_gnt);
    assign finish       = (state == WAIT_RVALID) && data_rvalid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (pop)         state_next = data_gnt ? WAIT_RVALID : WAIT_GNT;
            WAIT_GNT:    if (data_gnt)    state_next = WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid) state_next = EMIT;
            EMIT:                         state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_data_ready = (state == EMIT);
        orphan         = orphan_start;
        mem_data_o     = out_q;
    end

    // Skip counter: first the orphan's grant, then its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_active <= 1'b0;
            skip_gnt    <= 1'b0;
        end else if (!skip_active) begin
            if (orphan_start) begin
                skip_active <= 1'b1;
                skip_gnt    <= data_gnt;
            end
        end else if (!skip_gnt) begin
            if (data_gnt) skip_gnt <= 1'b1;
        end else if (data_rvalid) begin
            skip_active <= 1'b0;
            skip_gnt    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                          overflow <= 1'b0;
        else if (if_data_ready && fifo_full && !pop)      overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            wk_instr  <= head.instruction;
            wk_iaddr  <= head.instr_addr;
            wk_if_end <= head.if_end;
            wk_start  <= counter;
        end
        if (latch_addr) begin
            wk_maddr <= data_addr;
            wk_we    <= data_we;
        end
    end

    // The output record is captured on the response so it holds until the next EMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (finish) begin
            out_q.instruction <= wk_instr;
            out_q.instr_addr  <= wk_iaddr;
            out_q.if_end      <= wk_if_end;
            out_q.mem_start   <= wk_start;
            out_q.mem_end     <= counter;
            out_q.mem_addr    <= wk_maddr;
            out_q.is_store    <= wk_we;
            out_q.mismatch    <= wk_we ? !is_store_op(wk_instr) : !is_load_op(wk_instr);
        end
    end

endmodule

// File: tb/tb_mem_tracker.sv
// Directed self-checking bench for mem_tracker.
module tb_mem_tracker;
    import gouram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] counter;
    logic        if_data_ready;
    trace_format if_data_i;
    logic [31:0] if_stage_end;
    logic        data_req;
    logic        data_gnt;
    logic        data_we;
    logic [31:0] data_addr;
    logic        data_rvalid;
    logic        mem_data_ready;
    mem_trace_t  mem_data_o;
    logic        overflow;
    logic        orphan;

    int checks   = 0;
    int failures = 0;

    mem_tracker #(
        .INSTR_ADDR_WIDTH (16),
        .INSTR_DATA_WIDTH (32),
        .DATA_ADDR_WIDTH  (32),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .counter        (counter),
        .if_data_ready  (if_data_ready),
        .if_data_i      (if_data_i),
        .if_stage_end   (if_stage_end),
        .data_req       (data_req),
        .data_gnt       (data_gnt),
        .data_we        (data_we),
        .data_addr      (data_addr),
        .data_rvalid    (data_rvalid),
        .mem_data_ready (mem_data_ready),
        .mem_data_o     (mem_data_o),
        .overflow       (overflow),
        .orphan         (orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        counter = counter + 1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] instr, input logic [15:0] iaddr, input logic [31:0] ifend);
        if_data_ready = 1'b1;
        if_data_i.instruction = instr;
        if_data_i.instr_addr  = iaddr;
        if_stage_end = ifend;
        cyc();
        if_data_ready = 1'b0;
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic we,
                          output logic rdy, output mem_trace_t rec);
        data_req = 1'b1; data_gnt = 1'b1; data_we = we; data_addr = addr;
        cyc();
        data_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b1;
        cyc();
        rdy = mem_data_ready;
        rec = mem_data_o;
        data_rvalid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (mem_data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", mem_data_ready); end
        checks++;
        if (mem_data_o !== '0) begin failures++; $display("FAIL reset_record got=%h exp=0", mem_data_o); end
        checks++;
        if (overflow !== 1'b0 || orphan !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overflow, orphan); end
    endtask

    task automatic test_load();
        push(32'h0002A283, 16'h0040, 32'd10);
        counter = 32'd12;
        data_req = 1'b1; data_gnt = 1'b1; data_we = 1'b0; data_addr = 32'h1000;
        cyc();
        data_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b1;
        cyc();
        data_rvalid = 1'b0;
        checks++;
        if (mem_data_ready !== 1'b1 || counter !== 32'd14) begin failures++; $display("FAIL load_ready got=%b@%0d exp=1@14", mem_data_ready, counter); end
        checks++;
        if (mem_data_o.instruction !== 32'h0002A283 || mem_data_o.instr_addr !== 16'h0040 || mem_data_o.if_end !== 32'd10)
            begin failures++; $display("FAIL load_ifinfo got=%h/%h/%0d exp=0002a283/0040/10", mem_data_o.instruction, mem_data_o.instr_addr, mem_data_o.if_end); end
        checks++;
        if (mem_data_o.mem_start !== 32'd12 || mem_data_o.mem_end !== 32'd13)
            begin failures++; $display("FAIL load_times got=%0d/%0d exp=12/13", mem_data_o.mem_start, mem_data_o.mem_end); end
        checks++;
        if (mem_data_o.mem_addr !== 32'h1000 || mem_data_o.is_store !== 1'b0 || mem_data_o.mismatch !== 1'b0)
            begin failures++; $display("FAIL load_mem got=%h/%b/%b exp=1000/0/0", mem_data_o.mem_addr, mem_data_o.is_store, mem_data_o.mismatch); end
        cyc();
        checks++;
        if (mem_data_ready !== 1'b0 || mem_data_o.mem_start !== 32'd12)
            begin failures++; $display("FAIL load_pulse_hold got=%b/%0d exp=0/12", mem_data_ready, mem_data_o.mem_start); end
    endtask

    task automatic test_stall_gnt();
        push(32'h0062A023, 16'h0044, 32'd18);
        counter = 32'd20;
        data_req = 1'b1; data_gnt = 1'b0; data_we = 1'b1; data_addr = 32'hDEAD;
        cyc();
        cyc();
        cyc();
        data_gnt = 1'b1; data_addr = 32'h2000;
        cyc();
        data_req = 1'b0; data_gnt = 1'b0; data_addr = 32'hBEEF; data_rvalid = 1'b1;
        checks++;
        if (mem_data_ready !== 1'b0) begin failures++; $display("FAIL stall_early_ready got=%b exp=0", mem_data_ready); end
        cyc();
        data_rvalid = 1'b0;
        checks++;
        if (mem_data_ready !== 1'b1 || counter !== 32'd25) begin failures++; $display("FAIL stall_ready got=%b@%0d exp=1@25", mem_data_ready, counter); end
        checks++;
        if (mem_data_o.mem_start !== 32'd20 || mem_data_o.mem_end !== 32'd24 || mem_data_o.mem_addr !== 32'h2000)
            begin failures++; $display("FAIL stall_fields got=%0d/%0d/%h exp=20/24/2000", mem_data_o.mem_start, mem_data_o.mem_end, mem_data_o.mem_addr); end
        checks++;
        if (mem_data_o.is_store !== 1'b1 || mem_data_o.mismatch !== 1'b0)
            begin failures++; $display("FAIL stall_store got=%b/%b exp=1/0", mem_data_o.is_store, mem_data_o.mismatch); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic rdy;
        mem_trace_t rec;
        for (int i = 0; i < 3; i++) push(32'h0002A283, 16'(16'h0100 + 4*i), 32'(100 + i));
        for (int i = 0; i < 3; i++) begin
            do_txn(32'(32'h3000 + 16*i), 1'b0, rdy, rec);
            checks++;
            if (rdy !== 1'b1 || rec.instr_addr !== 16'(16'h0100 + 4*i) || rec.if_end !== 32'(100 + i) || rec.mem_addr !== 32'(32'h3000 + 16*i))
                begin failures++; $display("FAIL b2b_%0d got=%b/%h/%0d/%h exp=1/%h/%0d/%h", i, rdy, rec.instr_addr, rec.if_end, rec.mem_addr, 16'h0100 + 4*i, 100 + i, 32'h3000 + 16*i); end
        end
    endtask

    task automatic test_overflow();
        logic rdy;
        mem_trace_t rec;
        for (int i = 0; i < 4; i++) push(32'h0002A283, 16'(16'h0200 + 4*i), 32'(200 + i));
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_not_yet got=%b exp=0", overflow); end
        push(32'h0002A283, 16'h0210, 32'd204);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        for (int i = 0; i < 4; i++) begin
            do_txn(32'h4000, 1'b0, rdy, rec);
            checks++;
            if (rdy !== 1'b1 || rec.instr_addr !== 16'(16'h0200 + 4*i))
                begin failures++; $display("FAIL ovf_drain_%0d got=%b/%h exp=1/%h", i, rdy, rec.instr_addr, 16'h0200 + 4*i); end
        end
        data_req = 1'b1; data_gnt = 1'b1; data_we = 1'b0;
        #1;
        checks++;
        if (orphan !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_dropped_5th got=orphan%b/ovf%b exp=1/1", orphan, overflow); end
        cyc();
        data_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b1;
        cyc();
        data_rvalid = 1'b0;
        reset_dut();
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic rdy;
        mem_trace_t rec;
        for (int i = 0; i < 4; i++) push(32'h0002A283, 16'(16'h0300 + 4*i), 32'(300 + i));
        if_data_ready = 1'b1; if_data_i.instruction = 32'h0002A283; if_data_i.instr_addr = 16'h0310; if_stage_end = 32'd304;
        data_req = 1'b1; data_gnt = 1'b1; data_we = 1'b0; data_addr = 32'h5000;
        cyc();
        if_data_ready = 1'b0; data_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b1;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
        cyc();
        data_rvalid = 1'b0;
        checks++;
        if (mem_data_ready !== 1'b1 || mem_data_o.instr_addr !== 16'h0300)
            begin failures++; $display("FAIL fullpp_first got=%b/%h exp=1/0300", mem_data_ready, mem_data_o.instr_addr); end
        cyc();
        for (int i = 1; i < 5; i++) begin
            do_txn(32'h5000, 1'b0, rdy, rec);
            checks++;
            if (rdy !== 1'b1 || rec.instr_addr !== 16'(16'h0300 + 4*i))
                begin failures++; $display("FAIL fullpp_drain_%0d got=%b/%h exp=1/%h", i, rdy, rec.instr_addr, 16'h0300 + 4*i); end
        end
    endtask

    task automatic test_orphan_mismatch();
        logic rdy;
        mem_trace_t rec;
        logic [31:0] instrs [4] = '{32'h0002A283, 32'h0062A023, 32'h000000A3, 32'h00000083};
        logic        wes    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        exps   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int          pulses = 0;
        data_req = 1'b1; data_gnt = 1'b0; data_we = 1'b0; data_addr = 32'h6000;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) data_gnt = 1'b1;
            #1;
            if (orphan === 1'b1) pulses++;
            cyc();
        end
        data_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b1;
        #1;
        if (orphan === 1'b1) pulses++;
        cyc();
        data_rvalid = 1'b0;
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL orphan_pulses got=%0d exp=1", pulses); end
        checks++;
        if (mem_data_ready !== 1'b0) begin failures++; $display("FAIL orphan_no_record got=%b exp=0", mem_data_ready); end
        for (int i = 0; i < 4; i++) begin
            push(instrs[i], 16'(16'h0400 + 4*i), 32'd0);
            do_txn(32'h7000, wes[i], rdy, rec);
            checks++;
            if (rdy !== 1'b1 || rec.is_store !== wes[i] || rec.mismatch !== exps[i])
                begin failures++; $display("FAIL mismatch_%0d got=%b/%b/%b exp=1/%b/%b", i, rdy, rec.is_store, rec.mismatch, wes[i], exps[i]); end
        end
    endtask

    task automatic test_reset_mid_op();
        int seen = 0;
        push(32'h0002A283, 16'h0500, 32'd1);
        push(32'h0002A283, 16'h0504, 32'd2);
        data_req = 1'b1; data_gnt = 1'b1; data_we = 1'b0; data_addr = 32'h8000;
        cyc();
        data_req = 1'b0; data_gnt = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (mem_data_ready !== 1'b0 || mem_data_o !== '0 || overflow !== 1'b0 || orphan !== 1'b0)
            begin failures++; $display("FAIL midrst_outputs got=%b/%h/%b/%b exp=0/0/0/0", mem_data_ready, mem_data_o, overflow, orphan); end
        data_rvalid = 1'b1;
        cyc();
        data_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (mem_data_ready === 1'b1) seen++;
            cyc();
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midrst_late_rvalid got=%0d records exp=0", seen); end
        data_req = 1'b1; data_gnt = 1'b1;
        #1;
        checks++;
        if (orphan !== 1'b1) begin failures++; $display("FAIL midrst_fifo_empty got=orphan%b exp=1", orphan); end
        cyc();
        data_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b1;
        cyc();
        data_rvalid = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; counter = 32'd0; if_data_ready = 1'b0; if_data_i = '0; if_stage_end = '0;
        data_req = 1'b0; data_gnt = 1'b0; data_we = 1'b0; data_addr = '0; data_rvalid = 1'b0;
        test_reset();
        test_load();
        test_stall_gnt();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_orphan_mismatch();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
